regfile_write_arbiter: RTL and testbench

Owns the single register-file write port and shares it among three requesters: the WB-stage writeback, trap return-address saves to $k0, and UART receive bytes that are loaded into two fixed registers. WB has absolute priority. Trap and UART writes are buffered until the port is free. A starvation state machine raises a pipeline stall request when a buffered write has waited too long. The block sits between WB, the trap logic, the UART receiver and the RegisterFile write port.

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of every request, status and register-file write signal that
// crosses the arbiter boundary; the arbiter sits on the slave side.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        trap_req;
  logic [31:0] trap_data;
  logic        trap_busy;
  logic        uart_signal;
  logic        uart_flag;
  logic [7:0]  uart_rx_data;
  logic        uart_full;
  logic        uart_overflow;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_src;

  modport master (
    output wb_we, wb_waddr, wb_wdata, trap_req, trap_data,
           uart_signal, uart_flag, uart_rx_data,
    input  trap_busy, uart_full, uart_overflow, stall_req,
           rf_we, rf_waddr, rf_wdata, grant_src
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, trap_req, trap_data,
           uart_signal, uart_flag, uart_rx_data,
    output trap_busy, uart_full, uart_overflow, stall_req,
           rf_we, rf_waddr, rf_wdata, grant_src
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between WB (absolute priority),
// a buffered trap save and a small UART byte FIFO, with starvation stall request.
module regfile_write_arbiter #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [4:0] UART_REG0    = 5'd4,
  parameter logic [4:0] UART_REG1    = 5'd5,
  parameter logic [4:0] TRAP_REG     = 5'd26,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] cnt_q;
  logic          stall_q;
  logic          trap_pend_q, trap_busy_q;
  logic [31:0]   trap_data_q;
  logic [8:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, ovf_q;
  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;
  logic [1:0]    grant_q;

  logic          wb_win_s, grant_trap_s, grant_uart_s, any_grant_s;
  logic          fifo_empty_s, pending_s, blocked_s, capture_s, push_ok_s;
  logic          trap_pend_d, still_pending_s;
  logic [8:0]    head_s;
  logic [SW-1:0] cnt_inc_s;

  // A WB write to $0 is discarded, so it never claims the port.
  assign wb_win_s        = bus.wb_we && (bus.wb_waddr != 5'd0);
  assign fifo_empty_s    = (count_q == {CW{1'b0}});
  assign grant_trap_s    = !wb_win_s && trap_pend_q;
  assign grant_uart_s    = !wb_win_s && !trap_pend_q && !fifo_empty_s;
  assign any_grant_s     = grant_trap_s || grant_uart_s;
  assign pending_s       = trap_pend_q || !fifo_empty_s;
  assign blocked_s       = wb_win_s && pending_s;
  assign capture_s       = bus.trap_req && !trap_busy_q;
  assign push_ok_s       = bus.uart_signal && ((count_q != DEPTH_C) || grant_uart_s);
  assign trap_pend_d     = capture_s || (trap_pend_q && !grant_trap_s);
  assign still_pending_s = trap_pend_d || (count_d != {CW{1'b0}});
  assign head_s          = fifo_q[rd_ptr_q];
  assign cnt_inc_s       = cnt_q + SW'(1);

  // Next FIFO occupancy from the accepted push and the granted pop.
  always_comb begin
    count_d = count_q;
    if (push_ok_s && !grant_uart_s) begin
      count_d = count_q + CW'(1);
    end else if (grant_uart_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage; pointers are reset separately so the array stays plain memory.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_q[wr_ptr_q] <= {bus.uart_flag, bus.uart_rx_data};
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok_s)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (grant_uart_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      ovf_q   <= ovf_q || (bus.uart_signal && !push_ok_s);
    end
  end

  // Trap save buffer; busy stays high through the cycle the save is on the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_pend_q <= 1'b0;
      trap_busy_q <= 1'b0;
      trap_data_q <= 32'd0;
    end else begin
      trap_pend_q <= trap_pend_d;
      trap_busy_q <= trap_pend_q || capture_s;
      if (capture_s) trap_data_q <= bus.trap_data;
    end
  end

  // Registered write port: WB, then trap, then UART.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      grant_q    <= 2'b00;
    end else if (wb_win_s) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= bus.wb_waddr;
      rf_wdata_q <= bus.wb_wdata;
      grant_q    <= 2'b01;
    end else if (grant_trap_s) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= TRAP_REG;
      rf_wdata_q <= trap_data_q;
      grant_q    <= 2'b10;
    end else if (grant_uart_s) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head_s[8] ? UART_REG1 : UART_REG0;
      rf_wdata_q <= {24'd0, head_s[7:0]};
      grant_q    <= 2'b11;
    end else begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      grant_q    <= 2'b00;
    end
  end

  // Starvation FSM: counts cycles a buffered write loses to WB, stalls at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blocked_s) begin
            cnt_q <= SW'(1);
            if (SW'(1) >= LIMIT_C) begin
              state_q <= ST_FORCE;
              stall_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (any_grant_s) begin
            cnt_q   <= '0;
            state_q <= still_pending_s ? ST_WAIT : ST_IDLE;
          end else if (blocked_s) begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s >= LIMIT_C) begin
              state_q <= ST_FORCE;
              stall_q <= 1'b1;
            end
          end else if (!pending_s) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_FORCE: begin
          if (any_grant_s) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            state_q <= still_pending_s ? ST_WAIT : ST_IDLE;
          end else if (!pending_s) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.grant_src     = grant_q;
  assign bus.trap_busy     = trap_busy_q;
  assign bus.uart_full     = full_q;
  assign bus.uart_overflow = ovf_q;
  assign bus.stall_req     = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized plus directed bench; a queue-based reference model predicts every
// port write and flag, and an independent monitor compares after each edge.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .FIFO_DEPTH(DEPTH), .UART_REG0(5'd4), .UART_REG1(5'd5),
    .TRAP_REG(5'd26), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  logic [38:0] exp_q [$];
  logic [8:0]  uq [$];
  logic        m_pend = 1'b0, m_busy = 1'b0, m_ovf = 1'b0, m_full = 1'b0, m_stall = 1'b0;
  logic [31:0] m_tdata = 32'd0;
  int          streak = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected effect of the coming clock edge, from the current inputs.
  task automatic model_step();
    logic wb, old_pend, cap;
    logic [8:0] e;
    if (reset) begin
      m_pend = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_full = 1'b0; m_stall = 1'b0;
      uq.delete();
      streak = 0;
    end else begin
      wb = bus.wb_we && (bus.wb_waddr != 5'd0);
      old_pend = m_pend;
      cap = bus.trap_req && !m_busy;
      if (wb) begin
        exp_q.push_back({2'b01, bus.wb_waddr, bus.wb_wdata});
        if (m_pend || uq.size() > 0) streak++;
      end else if (m_pend) begin
        exp_q.push_back({2'b10, 5'd26, m_tdata});
        m_pend = 1'b0;
        streak = 0;
      end else if (uq.size() > 0) begin
        e = uq.pop_front();
        exp_q.push_back({2'b11, (e[8] ? 5'd5 : 5'd4), 24'd0, e[7:0]});
        streak = 0;
      end
      if (cap) begin
        m_pend = 1'b1;
        m_tdata = bus.trap_data;
      end
      m_busy = old_pend || cap;
      if (bus.uart_signal) begin
        if (uq.size() < DEPTH) uq.push_back({bus.uart_flag, bus.uart_rx_data});
        else m_ovf = 1'b1;
      end
      m_full = (uq.size() == DEPTH);
      m_stall = (streak >= LIMIT);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic tr, input logic [31:0] td,
                      input logic us, input logic uf, input logic [7:0] ub);
    @(negedge clk);
    reset = rst;
    bus.wb_we = we; bus.wb_waddr = wa; bus.wb_wdata = wd;
    bus.trap_req = tr; bus.trap_data = td;
    bus.uart_signal = us; bus.uart_flag = uf; bus.uart_rx_data = ub;
    model_step();
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic wb_busy(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 5'd9, 32'hC0DE_0000 + 32'(i), 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  // Monitor: samples one time unit after each rising edge.
  initial begin
    logic [38:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (bus.rf_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {63'd0, bus.rf_we}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("grant_src", {62'd0, bus.grant_src}, {62'd0, e[38:37]});
            chk("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e[36:32]});
            chk("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, e[31:0]});
          end
        end else begin
          chk("missing_write", 64'(exp_q.size()), 64'd0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          chk("idle_grant_src", {62'd0, bus.grant_src}, 64'd0);
        end
        chk("trap_busy", {63'd0, bus.trap_busy}, {63'd0, m_busy});
        chk("uart_full", {63'd0, bus.uart_full}, {63'd0, m_full});
        chk("uart_overflow", {63'd0, bus.uart_overflow}, {63'd0, m_ovf});
        chk("stall_req", {63'd0, bus.stall_req}, {63'd0, m_stall});
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.wb_we = 1'b0; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'd0;
    bus.trap_req = 1'b0; bus.trap_data = 32'd0;
    bus.uart_signal = 1'b0; bus.uart_flag = 1'b0; bus.uart_rx_data = 8'd0;

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    idle(2);

    // Plain WB write.
    step(1'b0, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    idle(2);

    // UART byte buffered behind WB, then WB targets $0 and the byte wins.
    step(1'b0, 1'b1, 5'd7, 32'hAAAA_0001, 1'b0, 32'd0, 1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    idle(2);

    // Trap collides with three WB writes.
    step(1'b0, 1'b1, 5'd8, 32'h1111_0000, 1'b1, 32'h0040_0010, 1'b0, 1'b0, 8'd0);
    wb_busy(3);
    idle(3);

    // Five pushes into a four-entry FIFO while WB holds the port.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 5'd10, 32'(i), 1'b0, 32'd0, 1'b1, 1'(i % 2), 8'(8'h11 * (i + 1)));
    idle(6);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    idle(1);

    // Starvation: trap pending under continuous WB writes.
    step(1'b0, 1'b1, 5'd11, 32'h2222_0000, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 8'd0);
    wb_busy(12);
    idle(3);

    // Fill the FIFO, then push and pop together at full, then reset mid-drain.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 5'd12, 32'(i), 1'b0, 32'd0, 1'b1, 1'(i % 2), 8'(8'h60 + i));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    idle(4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 31)),
           $urandom(),
           ($urandom_range(0, 99) < 10),
           $urandom(),
           ($urandom_range(0, 99) < 35),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end
    idle(20);

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
